// File: rtl/pc_update_unit_pkg.sv
// Shared types and helpers for the PC update unit.
// State encoding, redirect-source codes and the J-type target helper.
package pc_update_unit_pkg;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_SLOT = 1'b1
    } state_e;

    typedef enum logic [1:0] {
        SRC_SEQ = 2'd0,
        SRC_BR  = 2'd1,
        SRC_J   = 2'd2,
        SRC_JR  = 2'd3
    } src_e;

    localparam logic [31:0] PC_STEP = 32'd4;

    // J-type target: keep the 256 MB region of the jump's PC+4.
    function automatic logic [31:0] jump_target(input logic [31:0] pc_plus4,
                                                input logic [25:0] index);
        return {pc_plus4[31:28], index, 2'b00};
    endfunction

endpackage

// File: rtl/pc_update_unit_pc_target_mux.sv
// Redirect source priority select (jr > jump > branch) and target arithmetic.
// Purely combinational; all arithmetic wraps mod 2^32.
import pc_update_unit_pkg::*;

module pc_target_mux (
    input  logic [31:0] seq_pc,
    input  logic [31:0] id_pc_plus4,
    input  logic [31:0] br_offset_sl2,
    input  logic        branch_taken,
    input  logic        jump,
    input  logic [25:0] jump_index,
    input  logic        jr,
    input  logic [31:0] jr_addr,
    output src_e        src,
    output logic [31:0] target,
    output logic        jr_misalign
);

    // Priority select of the redirect source and its target address.
    always_comb begin
        src    = SRC_SEQ;
        target = seq_pc;
        if (jr) begin
            src    = SRC_JR;
            target = {jr_addr[31:2], 2'b00};
        end else if (jump) begin
            src    = SRC_J;
            target = jump_target(id_pc_plus4, jump_index);
        end else if (branch_taken) begin
            src    = SRC_BR;
            target = id_pc_plus4 + br_offset_sl2;
        end
    end

    assign jr_misalign = jr & (jr_addr[1:0] != 2'b00);

endmodule

// File: rtl/pc_update_unit.sv
// Program counter owner: PC register, pending-target register and the
// redirect FSM feeding the instruction-fetch valid/ready handshake.
// Optional MIPS delay slot enabled by defining DELAY_SLOT_EN.
//
// state | meaning
// ------+-----------------------------------------------------------------
// RUN   | normal sequencing; redirects are accepted
// SLOT  | delay-slot pc still waiting for fetch; tgt_q is issued on next adv
import pc_update_unit_pkg::*;

module pc_update_unit #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        if_ready,
    input  logic [31:0] id_pc_plus4,
    input  logic [31:0] br_offset_sl2,
    input  logic        branch_taken,
    input  logic        jump,
    input  logic [25:0] jump_index,
    input  logic        jr,
    input  logic [31:0] jr_addr,
    output logic [31:0] pc,
    output logic        pc_valid,
    output logic [31:0] pc_plus4,
    output logic        flush_if,
    output logic        misalign_err
);

    state_e      state;
    src_e        src;
    logic [31:0] target;
    logic        jr_misalign;
    logic        redirect;
    logic        accept;
    logic        adv;
`ifdef DELAY_SLOT_EN
    logic [31:0] tgt_q;
`endif

    pc_target_mux u_mux (
        .seq_pc        (pc_plus4),
        .id_pc_plus4   (id_pc_plus4),
        .br_offset_sl2 (br_offset_sl2),
        .branch_taken  (branch_taken),
        .jump          (jump),
        .jump_index    (jump_index),
        .jr            (jr),
        .jr_addr       (jr_addr),
        .src           (src),
        .target        (target),
        .jr_misalign   (jr_misalign)
    );

    assign pc_plus4 = pc + PC_STEP;
    assign adv      = pc_valid & if_ready & ~stall;
    assign redirect = (src != SRC_SEQ);
    // Redirect inputs are ignored while a delay-slot target is pending.
    assign accept   = redirect & (state == ST_RUN);

`ifdef DELAY_SLOT_EN
    // The current pc is the delay slot, so IF never needs killing.
    assign flush_if = 1'b0;
`else
    assign flush_if = rst_n & accept;
`endif

    // PC register, pending target and redirect FSM.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc           <= RESET_VECTOR;
            pc_valid     <= 1'b0;
            misalign_err <= 1'b0;
            state        <= ST_RUN;
`ifdef DELAY_SLOT_EN
            tgt_q        <= 32'h0000_0000;
`endif
        end else begin
            pc_valid     <= 1'b1;
            misalign_err <= accept & (src == SRC_JR) & jr_misalign;
`ifdef DELAY_SLOT_EN
            case (state)
                ST_RUN: begin
                    if (redirect) begin
                        if (adv) begin
                            pc <= target;
                        end else begin
                            tgt_q <= target;
                            state <= ST_SLOT;
                        end
                    end else if (adv) begin
                        pc <= pc_plus4;
                    end
                end
                ST_SLOT: begin
                    if (adv) begin
                        pc    <= tgt_q;
                        state <= ST_RUN;
                    end
                end
                default: state <= ST_RUN;
            endcase
`else
            // Without a delay slot the redirect overrides backpressure and stall.
            state <= ST_RUN;
            if (accept) begin
                pc <= target;
            end else if (adv) begin
                pc <= pc_plus4;
            end
`endif
        end
    end

endmodule

// File: tb/tb_pc_update_unit.sv
// Scoreboard bench for pc_update_unit: directed scenarios followed by
// randomized traffic, checked against a behavioural next-PC model.
module tb_pc_update_unit;

    localparam logic [31:0] RV = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        if_ready = 1'b0;
    logic [31:0] id_pc_plus4 = '0;
    logic [31:0] br_offset_sl2 = '0;
    logic        branch_taken = 1'b0;
    logic        jump = 1'b0;
    logic [25:0] jump_index = '0;
    logic        jr = 1'b0;
    logic [31:0] jr_addr = '0;
    logic [31:0] pc;
    logic        pc_valid;
    logic [31:0] pc_plus4;
    logic        flush_if;
    logic        misalign_err;

    pc_update_unit #(.RESET_VECTOR(RV)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall         (stall),
        .if_ready      (if_ready),
        .id_pc_plus4   (id_pc_plus4),
        .br_offset_sl2 (br_offset_sl2),
        .branch_taken  (branch_taken),
        .jump          (jump),
        .jump_index    (jump_index),
        .jr            (jr),
        .jr_addr       (jr_addr),
        .pc            (pc),
        .pc_valid      (pc_valid),
        .pc_plus4      (pc_plus4),
        .flush_if      (flush_if),
        .misalign_err  (misalign_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic        valid;
        logic        mis;
        logic        flush;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;

    // Behavioural model state
    logic [31:0] m_pc = RV;
    logic [31:0] m_tgt = '0;
    logic        m_valid = 1'b0;
    logic        m_mis = 1'b0;
    logic        m_slot = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Push this cycle's expected outputs, advance the model, then wait one clock.
    task automatic step();
        exp_t        e;
        logic        redir;
        logic        adv;
        logic [31:0] t;
        redir   = jr | jump | branch_taken;
        e.pc    = m_pc;
        e.valid = m_valid;
        e.mis   = m_mis;
`ifdef DELAY_SLOT_EN
        e.flush = 1'b0;
`else
        e.flush = rst_n & redir;
`endif
        sb.push_back(e);

        if (jr)
            t = jr_addr & 32'hFFFF_FFFC;
        else if (jump)
            t = (id_pc_plus4 & 32'hF000_0000) | (32'(jump_index) * 32'd4);
        else
            t = id_pc_plus4 + br_offset_sl2;
        adv = m_valid & if_ready & !stall;

        if (!rst_n) begin
            m_pc = RV; m_valid = 1'b0; m_mis = 1'b0; m_slot = 1'b0; m_tgt = '0;
        end else begin
`ifdef DELAY_SLOT_EN
            if (m_slot) begin
                m_mis = 1'b0;
                if (adv) begin
                    m_pc = m_tgt; m_slot = 1'b0;
                end
            end else begin
                m_mis = jr && (jr_addr % 4 != 0);
                if (redir) begin
                    if (adv) m_pc = t;
                    else begin
                        m_tgt = t; m_slot = 1'b1;
                    end
                end else if (adv) begin
                    m_pc = m_pc + 32'd4;
                end
            end
`else
            m_mis = jr && (jr_addr % 4 != 0);
            if (redir) m_pc = t;
            else if (adv) m_pc = m_pc + 32'd4;
`endif
            m_valid = 1'b1;
        end

        @(posedge clk);
        #1;
        jr = 1'b0; jump = 1'b0; branch_taken = 1'b0;
    endtask

    // Monitor: compare DUT outputs mid-cycle against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("pc", pc, e.pc);
                chk("pc_plus4", pc_plus4, e.pc + 32'd4);
                chk("pc_valid", {31'd0, pc_valid}, {31'd0, e.valid});
                chk("flush_if", {31'd0, flush_if}, {31'd0, e.flush});
                chk("misalign_err", {31'd0, misalign_err}, {31'd0, e.mis});
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        @(posedge clk);
        #1;
        // Reset and sequential run
        rst_n = 1'b0; if_ready = 1'b1;
        repeat (3) step();
        chk("rst_pc_valid", {31'd0, pc_valid}, 32'd0);
        chk("rst_pc", pc, RV);
        rst_n = 1'b1;
        step();
        chk("first_valid", {31'd0, pc_valid}, 32'd1);
        chk("seq0", pc, 32'h0);
        step(); chk("seq4", pc, 32'h4);
        step(); chk("seq8", pc, 32'h8);

        // Branches
        id_pc_plus4 = 32'h104; br_offset_sl2 = 32'h10; branch_taken = 1'b1;
        step(); chk("br_fwd", pc, 32'h114);
        id_pc_plus4 = 32'h104; br_offset_sl2 = 32'hFFFF_FFF0; branch_taken = 1'b1;
        step(); chk("br_back", pc, 32'hF4);

        // Jumps
        id_pc_plus4 = 32'h1000_0008; jump_index = 26'h40; jump = 1'b1;
        step(); chk("jump", pc, 32'h1000_0100);
        jr_addr = 32'h400; jr = 1'b1; jump = 1'b1;
        step(); chk("jr_over_jump", pc, 32'h400);

        // Misaligned jr
        jr_addr = 32'h203; jr = 1'b1;
        step();
        chk("jr_mis_pc", pc, 32'h200);
        chk("mis_pulse", {31'd0, misalign_err}, 32'd1);
        step();
        chk("mis_clear", {31'd0, misalign_err}, 32'd0);

        // Backpressure holds pc
        if_ready = 1'b0;
        repeat (4) step();
        chk("bp_hold", pc, 32'h204);

        // Branch during backpressure
        id_pc_plus4 = 32'h300; br_offset_sl2 = 32'h20; branch_taken = 1'b1;
        step();
`ifdef DELAY_SLOT_EN
        chk("slot_pc_first", pc, 32'h204);
        if_ready = 1'b1;
        step();
        chk("slot_target", pc, 32'h320);
`else
        chk("bp_redirect", pc, 32'h320);
`endif

        // Wrap
        if_ready = 1'b1;
        jr_addr = 32'hFFFF_FFFC; jr = 1'b1;
        step(); chk("wrap_pre", pc, 32'hFFFF_FFFC);
        step(); chk("wrap", pc, 32'h0);

        // Reset while a target may be pending
        if_ready = 1'b0;
        id_pc_plus4 = 32'h500; br_offset_sl2 = 32'h0; branch_taken = 1'b1;
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1; if_ready = 1'b1;
        step(); chk("rst_mid_pc", pc, RV);
        step(); chk("rst_drop_tgt", pc, RV + 32'd4);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            int r;
            rst_n         = ($urandom_range(0, 59) != 0);
            stall         = ($urandom_range(0, 3) == 0);
            if_ready      = ($urandom_range(0, 3) != 0);
            id_pc_plus4   = $urandom;
            br_offset_sl2 = $urandom;
            jump_index    = 26'($urandom);
            jr_addr       = $urandom;
            r             = $urandom_range(0, 11);
            branch_taken  = (r == 0) || (r == 4);
            jump          = (r == 1) || (r == 3) || (r == 4);
            jr            = (r == 2) || (r == 3);
            step();
        end

        rst_n = 1'b1; stall = 1'b0; if_ready = 1'b1;
        step();
        step();
        chk("sb_drain", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
